if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC, selects next PC (sequential / branch / jump) and runs a one-outstanding request/ready handshake to instruction memory.
- Registered outputs feed the IF/ID register's I_PC, I_PC4 and I_Inst inputs.
- Supports stall (hold) and redirect (flush to NOP bubble).

---
 rtl/if_fetch_stage_if.sv | 22 ++
 rtl/if_fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch handshake: one outstanding request, data returned
// in the cycle IMem_Ready is high.
interface if_fetch_stage_if;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ready;
  logic [31:0] IMem_Data;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Ready,
    input  IMem_Data
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Ready,
    output IMem_Data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding fetch to
// instruction memory and presents registered PC/PC+4/instruction to IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target,
  input  logic              Jump,
  input  logic [31:0]       Jump_Target,
  if_fetch_stage_if.master  imem,
  output logic [31:0]       O_PC,
  output logic [31:0]       O_PC4,
  output logic [31:0]       O_Inst,
  output logic              O_Valid
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] buf_inst_reg, buf_inst_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] o_pc_reg, o_pc_next;
  logic [31:0] o_pc4_reg, o_pc4_next;
  logic [31:0] o_inst_reg, o_inst_next;
  logic        o_valid_reg, o_valid_next;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Branch wins over jump; targets are always word aligned.
  assign redirect = Branch_Taken | Jump;
  assign target   = (Branch_Taken ? Branch_Target : Jump_Target) & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_reg + 32'd4;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= S_REQ;
      pc_reg       <= RESET_PC;
      req_addr_reg <= RESET_PC;
      buf_inst_reg <= NOP_INST;
      buf_pc_reg   <= 32'd0;
      o_pc_reg     <= 32'd0;
      o_pc4_reg    <= 32'd0;
      o_inst_reg   <= NOP_INST;
      o_valid_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
      buf_inst_reg <= buf_inst_next;
      buf_pc_reg   <= buf_pc_next;
      o_pc_reg     <= o_pc_next;
      o_pc4_reg    <= o_pc4_next;
      o_inst_reg   <= o_inst_next;
      o_valid_reg  <= o_valid_next;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    req_addr_next = req_addr_reg;
    buf_inst_next = buf_inst_reg;
    buf_pc_next   = buf_pc_reg;
    o_pc_next     = o_pc_reg;
    o_pc4_next    = o_pc4_reg;
    o_inst_next   = o_inst_reg;
    o_valid_next  = o_valid_reg;

    case (state_reg)
      S_REQ: begin
        if (redirect) begin
          pc_next       = target;
          o_inst_next   = NOP_INST;
          o_valid_next  = 1'b0;
          buf_inst_next = NOP_INST;
          if (imem.IMem_Ready) begin
            req_addr_next = target;
            state_next    = S_REQ;
          end else begin
            // The old request is still in flight; its response must be eaten.
            state_next = S_DISCARD;
          end
        end else if (imem.IMem_Ready) begin
          if (!Stall) begin
            o_pc_next     = pc_reg;
            o_pc4_next    = pc_plus4;
            o_inst_next   = imem.IMem_Data;
            o_valid_next  = 1'b1;
            pc_next       = pc_plus4;
            req_addr_next = pc_plus4;
          end else begin
            buf_inst_next = imem.IMem_Data;
            buf_pc_next   = pc_reg;
            state_next    = S_HOLD;
          end
        end else if (!Stall) begin
          o_inst_next  = NOP_INST;
          o_valid_next = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_next       = target;
          req_addr_next = target;
          o_inst_next   = NOP_INST;
          o_valid_next  = 1'b0;
          buf_inst_next = NOP_INST;
          state_next    = S_REQ;
        end else if (!Stall) begin
          o_pc_next     = buf_pc_reg;
          o_pc4_next    = buf_pc_reg + 32'd4;
          o_inst_next   = buf_inst_reg;
          o_valid_next  = 1'b1;
          pc_next       = pc_plus4;
          req_addr_next = pc_plus4;
          state_next    = S_REQ;
        end
      end

      S_DISCARD: begin
        if (redirect) begin
          pc_next = target;
        end
        if (imem.IMem_Ready) begin
          req_addr_next = pc_next;
          state_next    = S_REQ;
        end
      end

      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // Outputs
  always_comb begin
    imem.IMem_Req  = 1'b0;
    imem.IMem_Addr = req_addr_reg;
    if (!Reset && (state_reg != S_HOLD)) begin
      imem.IMem_Req = 1'b1;
    end
  end

  assign O_PC    = o_pc_reg;
  assign O_PC4   = o_pc4_reg;
  assign O_Inst  = o_inst_reg;
  assign O_Valid = o_valid_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small instruction-memory model
// whose response latency and readiness are set per scenario.
module tb_if_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic [31:0] O_PC, O_PC4, O_Inst;
  logic        O_Valid;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  // Memory model: ready after `lat` pending cycles, gated by ready_en.
  int unsigned lat = 0;
  logic        ready_en = 1'b1;
  int unsigned cnt = 0;

  if_fetch_stage_if imem ();

  if_fetch_stage dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Jump          (Jump),
    .Jump_Target   (Jump_Target),
    .imem          (imem.master),
    .O_PC          (O_PC),
    .O_PC4         (O_PC4),
    .O_Inst        (O_Inst),
    .O_Valid       (O_Valid)
  );

  always #5 Clk = ~Clk;

  assign imem.IMem_Ready = imem.IMem_Req && ready_en && (cnt >= lat);
  assign imem.IMem_Data  = imem.IMem_Addr ^ KEY;

  always @(posedge Clk) begin
    if (Reset || !imem.IMem_Req || imem.IMem_Ready) cnt <= 0;
    else                                           cnt <= cnt + 1;
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic valid);
    check32({tag, ".pc"},    O_PC,    pc);
    check32({tag, ".pc4"},   O_PC4,   pc + 32'd4);
    check32({tag, ".inst"},  O_Inst,  inst);
    check32({tag, ".valid"}, {31'd0, O_Valid}, {31'd0, valid});
  endtask

  task automatic do_reset();
    Reset = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0; Jump = 1'b0;
    lat = 0; ready_en = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0;
    Branch_Taken = 1'b0; Branch_Target = 32'd0;
    Jump = 1'b0; Jump_Target = 32'd0;

    // Reset state
    step();
    step();
    check32("rst.pc",    O_PC,    32'd0);
    check32("rst.pc4",   O_PC4,   32'd0);
    check32("rst.inst",  O_Inst,  32'd0);
    check32("rst.valid", {31'd0, O_Valid}, 32'd0);
    check32("rst.req",   {31'd0, imem.IMem_Req}, 32'd0);

    // Zero-wait memory: one instruction per cycle
    Reset = 1'b0;
    #1;
    check32("zw.req0",  {31'd0, imem.IMem_Req}, 32'd1);
    check32("zw.addr0", imem.IMem_Addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("zw%0d", i), 32'(i * 4), KEY ^ 32'(i * 4), 1'b1);
    end

    // Two wait cycles per fetch: two bubbles, address stable
    lat = 2;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 2; b++) begin
        step();
        check32($sformatf("lat%0d.b%0d.valid", k, b), {31'd0, O_Valid}, 32'd0);
        check32($sformatf("lat%0d.b%0d.inst", k, b), O_Inst, 32'd0);
        check32($sformatf("lat%0d.b%0d.addr", k, b), imem.IMem_Addr, 32'(12 + k * 4));
      end
      step();
      expect_out($sformatf("lat%0d", k), 32'(12 + k * 4), KEY ^ 32'(12 + k * 4), 1'b1);
    end

    // Stall for 3 cycles while the PC=8 response arrives
    do_reset();
    step();
    step();
    expect_out("st.pre", 32'd4, KEY ^ 32'd4, 1'b1);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("st.hold%0d", i), 32'd4, KEY ^ 32'd4, 1'b1);
      check32($sformatf("st.hold%0d.req", i), {31'd0, imem.IMem_Req}, 32'd0);
    end
    Stall = 1'b0;
    step();
    expect_out("st.rel", 32'd8, KEY ^ 32'd8, 1'b1);
    step();
    expect_out("st.next", 32'd12, KEY ^ 32'd12, 1'b1);

    // Branch while the request at 0xC is pending
    do_reset();
    step(); step(); step();
    expect_out("br.pre", 32'd8, KEY ^ 32'd8, 1'b1);
    ready_en = 1'b0;
    Branch_Taken = 1'b1; Branch_Target = 32'h100;
    step();
    Branch_Taken = 1'b0;
    check32("br.valid", {31'd0, O_Valid}, 32'd0);
    check32("br.inst",  O_Inst, 32'd0);
    check32("br.oldaddr", imem.IMem_Addr, 32'h0C);
    check32("br.req", {31'd0, imem.IMem_Req}, 32'd1);
    ready_en = 1'b1;
    step();
    check32("br.drop.valid", {31'd0, O_Valid}, 32'd0);
    check32("br.newaddr", imem.IMem_Addr, 32'h100);
    step();
    expect_out("br.tgt", 32'h100, KEY ^ 32'h100, 1'b1);

    // Branch and jump together: branch wins
    Branch_Taken = 1'b1; Branch_Target = 32'h200;
    Jump = 1'b1; Jump_Target = 32'h300;
    step();
    Branch_Taken = 1'b0; Jump = 1'b0;
    check32("bj.valid", {31'd0, O_Valid}, 32'd0);
    check32("bj.addr", imem.IMem_Addr, 32'h200);
    step();
    expect_out("bj.tgt", 32'h200, KEY ^ 32'h200, 1'b1);

    // Misaligned jump target is word aligned
    Jump = 1'b1; Jump_Target = 32'h203;
    step();
    Jump = 1'b0;
    check32("mis.valid", {31'd0, O_Valid}, 32'd0);
    check32("mis.addr", imem.IMem_Addr, 32'h200);
    step();
    expect_out("mis.tgt", 32'h200, KEY ^ 32'h200, 1'b1);

    // PC+4 wraps modulo 2^32
    Jump = 1'b1; Jump_Target = 32'hFFFF_FFFC;
    step();
    Jump = 1'b0;
    step();
    expect_out("wrap.top", 32'hFFFF_FFFC, KEY ^ 32'hFFFF_FFFC, 1'b1);
    check32("wrap.pc4", O_PC4, 32'd0);
    step();
    expect_out("wrap.zero", 32'd0, KEY, 1'b1);

    // Reset while in S_HOLD
    Stall = 1'b1;
    step();
    check32("rh.hold.req", {31'd0, imem.IMem_Req}, 32'd0);
    Reset = 1'b1;
    step();
    check32("rh.pc",    O_PC,    32'd0);
    check32("rh.pc4",   O_PC4,   32'd0);
    check32("rh.inst",  O_Inst,  32'd0);
    check32("rh.valid", {31'd0, O_Valid}, 32'd0);
    check32("rh.req",   {31'd0, imem.IMem_Req}, 32'd0);
    Reset = 1'b0; Stall = 1'b0;
    #1;
    check32("rh.req1",  {31'd0, imem.IMem_Req}, 32'd1);
    check32("rh.addr1", imem.IMem_Addr, 32'd0);
    step();
    expect_out("rh.first", 32'd0, KEY, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
